// File: rtl/fft_pkg.sv
// FFT writeback shared types: widths, result-pair bundle, FSM states,
// size-code helpers and address bit reversal.
package fft_pkg;

    localparam int DATA_W = 128;
    localparam int ADDR_W = 8;
    localparam int CNT_W  = ADDR_W + 1;

    typedef struct packed {
        logic [DATA_W-1:0] data1;
        logic [ADDR_W-1:0] addr1;
        logic [DATA_W-1:0] data2;
        logic [ADDR_W-1:0] addr2;
    } wb_pair_t;

    typedef enum logic [1:0] {
        IDLE,
        WR1,
        WR2
    } wb_state_t;

    function automatic logic [2:0] cfg_clamp(input logic [2:0] cfg);
        return (cfg == 3'd7) ? 3'd6 : cfg;
    endfunction

    function automatic logic [CNT_W-1:0] cfg_to_words(input logic [2:0] cfg);
        return CNT_W'(4) << cfg_clamp(cfg);
    endfunction

    function automatic logic [3:0] cfg_to_log2(input logic [2:0] cfg);
        return {1'b0, cfg_clamp(cfg)} + 4'd2;
    endfunction

    function automatic logic [ADDR_W-1:0] bitrev(
        input logic [ADDR_W-1:0] addr,
        input logic [3:0]        log2w
    );
        logic [ADDR_W-1:0] rev;
        for (int i = 0; i < ADDR_W; i++) begin
            rev[i] = addr[ADDR_W-1-i];
        end
        return rev >> (4'(ADDR_W) - log2w);
    endfunction

endpackage

// File: rtl/fft_wb_fifo.sv
// Result-pair FIFO for the FFT writeback path. A flush empties it; a push
// in the flush cycle lands as the first entry of the fresh contents.
module fft_wb_fifo
    import fft_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     i_reset,
    input  logic     i_push,
    input  logic     i_pop,
    input  logic     i_flush,
    input  wb_pair_t i_data,
    output wb_pair_t o_head,
    output logic     o_full,
    output logic     o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_pair_t      mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [PW-1:0] wr_idx;

    assign wr_idx  = i_flush ? '0 : wr_ptr;
    assign o_head  = mem[rd_ptr];
    assign o_full  = (count == CW'(DEPTH));
    assign o_empty = (count == '0);

    // storage write, no reset needed on payload
    always_ff @(posedge clk) begin
        if (i_push) begin
            mem[wr_idx] <= i_data;
        end
    end

    // pointers and occupancy
    always_ff @(posedge clk) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_flush) begin
            rd_ptr <= '0;
            wr_ptr <= i_push ? PW'(1) : '0;
            count  <= i_push ? CW'(1) : '0;
        end else begin
            if (i_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (i_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(i_push) - CW'(i_pop);
        end
    end

endmodule

// File: rtl/fft_writeback.sv
// FFT result writeback: buffers butterfly pairs and drains one word per cycle.
// Optional FFT_WB_BITREV_EN: bit-reversed addresses on the final stage.
module fft_writeback
    import fft_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic [2:0]        i_point_configuration,
    input  logic              i_stage_start,
    input  logic              i_last_stage,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data1,
    input  logic [DATA_W-1:0] i_data2,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [ADDR_W-1:0] i_addr2,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_busy,
    output logic              o_stage_done,
    output logic              o_err_overflow,
    output logic              o_err_count
);

    wb_state_t         state_q;
    wb_state_t         state_d;
    wb_pair_t          push_pair;
    wb_pair_t          head;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              ovf;
    logic              we_d;
    logic              done_d;
    logic              armed_q;
    logic              last_q;
    logic [2:0]        cfg_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  words;
    logic [ADDR_W-1:0] raw_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] raw_data;

    assign push_pair = {i_data1, i_addr1, i_data2, i_addr2};
    // a start flushes first, so a same-cycle pair always fits
    assign push      = i_valid && (i_stage_start || !full);
    assign ovf       = i_valid && full && !i_stage_start;

    fft_wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .i_reset (i_reset),
        .i_push  (push),
        .i_pop   (pop),
        .i_flush (i_stage_start),
        .i_data  (push_pair),
        .o_head  (head),
        .o_full  (full),
        .o_empty (empty)
    );

    // next-state: WR1 writes word 1, WR2 writes word 2 and retires the pair
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: if (!empty) state_d = WR1;
            WR1: begin
                state_d = WR2;
                pop     = 1'b1;
            end
            WR2:     state_d = empty ? IDLE : WR1;
            default: state_d = IDLE;
        endcase
        if (i_stage_start) begin
            state_d = IDLE;
            pop     = 1'b0;
        end
    end

    assign we_d     = (state_d != IDLE);
    assign raw_addr = (state_d == WR1) ? head.addr1 : head.addr2;
    assign raw_data = (state_d == WR1) ? head.data1 : head.data2;
    assign words    = cfg_to_words(cfg_q);
    assign done_d   = armed_q && (state_q == WR2) && empty
                    && (cnt_q == words);
    assign o_busy   = !empty || (state_q != IDLE);

`ifdef FFT_WB_BITREV_EN
    assign wr_addr = last_q ? bitrev(raw_addr, cfg_to_log2(cfg_q))
                            : raw_addr;
`else
    logic unused_last;
    assign unused_last = last_q;
    assign wr_addr     = raw_addr;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // registered memory port; address/data hold while idle
    always_ff @(posedge clk) begin
        if (i_reset) begin
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
        end else begin
            o_mem_we <= we_d;
            if (we_d) begin
                o_mem_addr  <= wr_addr;
                o_mem_wdata <= raw_data;
            end
        end
    end

    // completion pulse and sticky error flags
    always_ff @(posedge clk) begin
        if (i_reset) begin
            o_stage_done   <= 1'b0;
            o_err_overflow <= 1'b0;
            o_err_count    <= 1'b0;
        end else begin
            o_stage_done <= done_d;
            if (ovf) begin
                o_err_overflow <= 1'b1;
            end
            if (we_d && (!armed_q || cnt_q >= words)) begin
                o_err_count <= 1'b1;
            end
        end
    end

    // stage arming, size latch and saturating word counter
    always_ff @(posedge clk) begin
        if (i_reset) begin
            armed_q <= 1'b0;
            last_q  <= 1'b0;
            cfg_q   <= '0;
            cnt_q   <= '0;
        end else if (i_stage_start) begin
            armed_q <= 1'b1;
            last_q  <= i_last_stage;
            cfg_q   <= i_point_configuration;
            cnt_q   <= '0;
        end else begin
            if (done_d) begin
                armed_q <= 1'b0;
            end
            if (we_d && armed_q && cnt_q <= words) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fft_writeback.sv
// Directed bench for fft_writeback with an expected-write scoreboard.
// Each pushed pair queues its two writes; the monitor pops on o_mem_we.
module tb_fft_writeback;
    import fft_pkg::*;

    logic              clk = 1'b0;
    logic              i_reset;
    logic [2:0]        i_point_configuration;
    logic              i_stage_start;
    logic              i_last_stage;
    logic              i_valid;
    logic [DATA_W-1:0] i_data1;
    logic [DATA_W-1:0] i_data2;
    logic [ADDR_W-1:0] i_addr1;
    logic [ADDR_W-1:0] i_addr2;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic              o_busy;
    logic              o_stage_done;
    logic              o_err_overflow;
    logic              o_err_count;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_err  = 0;
    int   n_done = 0;
    int   d0     = 0;

    fft_writeback #(
        .FIFO_DEPTH (4)
    ) dut (
        .clk                   (clk),
        .i_reset               (i_reset),
        .i_point_configuration (i_point_configuration),
        .i_stage_start         (i_stage_start),
        .i_last_stage          (i_last_stage),
        .i_valid               (i_valid),
        .i_data1               (i_data1),
        .i_data2               (i_data2),
        .i_addr1               (i_addr1),
        .i_addr2               (i_addr2),
        .o_mem_we              (o_mem_we),
        .o_mem_addr            (o_mem_addr),
        .o_mem_wdata           (o_mem_wdata),
        .o_busy                (o_busy),
        .o_stage_done          (o_stage_done),
        .o_err_overflow        (o_err_overflow),
        .o_err_count           (o_err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] mk(input int k);
        logic [31:0] v;
        v = 32'(k);
        return {32'hD000_0000 ^ v, 32'hC000_0000 ^ v,
                32'hB000_0000 ^ v, 32'hA000_0000 ^ v};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_x(input logic [ADDR_W-1:0] a1,
                           input logic [ADDR_W-1:0] a2,
                           input logic [ADDR_W-1:0] e1,
                           input logic [ADDR_W-1:0] e2,
                           input int k, input bit acc);
        i_valid = 1'b1;
        i_addr1 = a1;
        i_addr2 = a2;
        i_data1 = mk(2 * k);
        i_data2 = mk(2 * k + 1);
        if (acc) begin
            exp_q.push_back('{a: e1, d: mk(2 * k)});
            exp_q.push_back('{a: e2, d: mk(2 * k + 1)});
        end
    endtask

    task automatic drive(input logic [ADDR_W-1:0] a1,
                         input logic [ADDR_W-1:0] a2,
                         input int k, input bit acc);
        drive_x(a1, a2, a1, a2, k, acc);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (o_busy !== 1'b0 && k < 200) begin
            cyc();
            k++;
        end
        chk(tag, 128'(o_busy), 128'(0));
    endtask

    task automatic start(input logic [2:0] cfg, input logic last);
        i_stage_start         = 1'b1;
        i_point_configuration = cfg;
        i_last_stage          = last;
    endtask

    // scoreboard: every memory write must match the oldest expected one
    always @(negedge clk) begin
        exp_t e;
        if (o_stage_done === 1'b1) n_done++;
        if (o_mem_we === 1'b1) begin
            chk("wr_expected", 128'(exp_q.size() != 0), 128'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", 128'(o_mem_addr), 128'(e.a));
                chk("wr_data", o_mem_wdata, e.d);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset               = 1'b1;
        i_point_configuration = '0;
        i_stage_start         = 1'b0;
        i_last_stage          = 1'b0;
        i_valid               = 1'b0;
        i_data1               = '0;
        i_data2               = '0;
        i_addr1               = '0;
        i_addr2               = '0;
        cyc(); cyc(); cyc();
        chk("rst_we", 128'(o_mem_we), 128'(0));
        chk("rst_busy", 128'(o_busy), 128'(0));
        chk("rst_done", 128'(o_stage_done), 128'(0));
        chk("rst_ovf", 128'(o_err_overflow), 128'(0));
        chk("rst_errc", 128'(o_err_count), 128'(0));
        chk("rst_addr", 128'(o_mem_addr), 128'(0));
        chk("rst_wdata", o_mem_wdata, 128'(0));
        i_reset = 1'b0;
        cyc();

        // W=4: pairs (0,2),(1,3) back to back
        d0 = n_done;
        start(3'd0, 1'b0);
        cyc();
        i_stage_start = 1'b0;
        drive(8'd0, 8'd2, 0, 1'b1);
        cyc();
        drive(8'd1, 8'd3, 1, 1'b1);
        cyc();
        i_valid = 1'b0;
        chk("a_lat_we", 128'(o_mem_we), 128'(1));
        chk("a_lat_addr", 128'(o_mem_addr), 128'(0));
        cyc(); cyc(); cyc();
        chk("a_last_we", 128'(o_mem_we), 128'(1));
        chk("a_last_addr", 128'(o_mem_addr), 128'(3));
        chk("a_done_early", 128'(o_stage_done), 128'(0));
        cyc();
        chk("a_done", 128'(o_stage_done), 128'(1));
        chk("a_busy", 128'(o_busy), 128'(0));
        cyc();
        chk("a_done_pulse", 128'(o_stage_done), 128'(0));
        chk("a_done_cnt", 128'(n_done - d0), 128'(1));
        chk("a_ovf", 128'(o_err_overflow), 128'(0));
        chk("a_errc", 128'(o_err_count), 128'(0));

        // W=16: 6-pair burst fits, then 2 more incl. addr1==addr2
        d0 = n_done;
        start(3'd2, 1'b0);
        cyc();
        i_stage_start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive(8'(16 + 2 * k), 8'(17 + 2 * k), 10 + k, 1'b1);
            cyc();
        end
        i_valid = 1'b0;
        chk("b_ovf", 128'(o_err_overflow), 128'(0));
        wait_idle("b_idle1");
        drive(8'd40, 8'd40, 16, 1'b1);
        cyc();
        drive(8'd41, 8'd42, 17, 1'b1);
        cyc();
        i_valid = 1'b0;
        wait_idle("b_idle2");
        cyc(); cyc();
        chk("b_done", 128'(n_done - d0), 128'(1));
        chk("b_errc", 128'(o_err_count), 128'(0));

        // W=32: 12-pair burst; pairs 6, 8, 10 find the FIFO full
        d0 = n_done;
        start(3'd3, 1'b0);
        cyc();
        i_stage_start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            drive(8'(2 * k), 8'(2 * k + 1), 30 + k,
                  !(k == 6 || k == 8 || k == 10));
            cyc();
        end
        i_valid = 1'b0;
        chk("c_ovf", 128'(o_err_overflow), 128'(1));
        wait_idle("c_idle");
        cyc(); cyc();
        chk("c_nodone", 128'(n_done - d0), 128'(0));
        chk("c_errc", 128'(o_err_count), 128'(0));

        // restart mid-drain with two pairs queued
        start(3'd0, 1'b0);
        cyc();
        i_stage_start = 1'b0;
        drive(8'd0, 8'd1, 50, 1'b1);
        cyc();
        drive(8'd2, 8'd3, 51, 1'b1);
        cyc();
        drive(8'd0, 8'd1, 52, 1'b1);
        cyc();
        i_valid = 1'b0;
        i_stage_start = 1'b1;
        cyc();
        i_stage_start = 1'b0;
        exp_q.delete();
        chk("d_we_drop", 128'(o_mem_we), 128'(0));
        chk("d_busy", 128'(o_busy), 128'(0));
        d0 = n_done;
        drive(8'd2, 8'd3, 53, 1'b1);
        cyc();
        drive(8'd0, 8'd1, 54, 1'b1);
        cyc();
        i_valid = 1'b0;
        wait_idle("d_idle");
        cyc(); cyc();
        chk("d_done", 128'(n_done - d0), 128'(1));
        chk("d_errc", 128'(o_err_count), 128'(0));

        // pair in the start cycle belongs to the new stage; then an extra pair
        d0 = n_done;
        start(3'd0, 1'b0);
        drive(8'd5, 8'd6, 60, 1'b1);
        cyc();
        i_stage_start = 1'b0;
        drive(8'd7, 8'd8, 61, 1'b1);
        cyc();
        i_valid = 1'b0;
        wait_idle("e_idle1");
        cyc(); cyc();
        chk("e_done", 128'(n_done - d0), 128'(1));
        chk("e_errc0", 128'(o_err_count), 128'(0));
        drive(8'd9, 8'd10, 62, 1'b1);
        cyc();
        i_valid = 1'b0;
        wait_idle("e_idle2");
        cyc(); cyc();
        chk("e_errc1", 128'(o_err_count), 128'(1));
        chk("e_nodone2", 128'(n_done - d0), 128'(1));

        // final-stage addressing, W=8, addr1=1 addr2=6
        start(3'd1, 1'b1);
`ifdef FFT_WB_BITREV_EN
        drive_x(8'd1, 8'd6, 8'd4, 8'd3, 70, 1'b1);
`else
        drive_x(8'd1, 8'd6, 8'd1, 8'd6, 70, 1'b1);
`endif
        cyc();
        i_stage_start = 1'b0;
        i_last_stage  = 1'b0;
        i_valid       = 1'b0;
        cyc();
`ifdef FFT_WB_BITREV_EN
        chk("f_last_addr1", 128'(o_mem_addr), 128'(4));
`else
        chk("f_last_addr1", 128'(o_mem_addr), 128'(1));
`endif
        wait_idle("f_idle1");
        start(3'd1, 1'b0);
        drive(8'd1, 8'd6, 71, 1'b1);
        cyc();
        i_stage_start = 1'b0;
        i_valid       = 1'b0;
        cyc();
        chk("f_nat_addr1", 128'(o_mem_addr), 128'(1));
        wait_idle("f_idle2");

        // reset while a WR2 write is visible and a pair is still queued
        chk("g_ovf_pre", 128'(o_err_overflow), 128'(1));
        chk("g_errc_pre", 128'(o_err_count), 128'(1));
        start(3'd0, 1'b0);
        cyc();
        i_stage_start = 1'b0;
        drive(8'd1, 8'd2, 80, 1'b1);
        cyc();
        drive(8'd3, 8'd0, 81, 1'b1);
        cyc();
        i_valid = 1'b0;
        cyc();
        chk("g_in_wr2", 128'(o_mem_addr), 128'(2));
        i_reset = 1'b1;
        cyc();
        exp_q.delete();
        chk("g_we", 128'(o_mem_we), 128'(0));
        chk("g_busy", 128'(o_busy), 128'(0));
        chk("g_ovf", 128'(o_err_overflow), 128'(0));
        chk("g_errc", 128'(o_err_count), 128'(0));
        chk("g_addr", 128'(o_mem_addr), 128'(0));
        i_reset = 1'b0;
        cyc(); cyc(); cyc(); cyc();
        chk("g_quiet", 128'(o_busy), 128'(0));
        chk("q_empty", 128'(exp_q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
